red_pipe: RTL and testbench

//  Pipelined, parametrised packed-lane reduction unit for the ALU's RED operation: sums all LANE_W-bit lanes of
//  in_data (signed or unsigned per op) through a registered adder tree, optionally accumulating across ops,

---
 rtl/red_pipe_if.sv | 25 ++
 rtl/red_pipe.sv | 139 +++++++++++++
 tb/tb_red_pipe.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/red_pipe_if.sv
// Handshake bundle for red_pipe: issue side (in_*) and writeback side (out_*).
interface red_pipe_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned OUT_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_signed;
   logic              in_acc;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  out_result;
   logic              out_ovf;

   modport master (
      output in_valid, in_data, in_signed, in_acc, out_ready,
      input  in_ready, out_valid, out_result, out_ovf
   );

   modport slave (
      input  in_valid, in_data, in_signed, in_acc, out_ready,
      output in_ready, out_valid, out_result, out_ovf
   );
endinterface

// File: rtl/red_pipe.sv
// Pipelined packed-lane reduction: lane extend, registered adder tree, then an
// accumulate stage with wrap/saturate. One global stall enable for all stages.
module red_pipe #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned LANE_W = 4,
   parameter int unsigned OUT_W  = 16,
   parameter bit          SAT    = 1'b0
) (
   input logic       clk,
   input logic       rst,
   red_pipe_if.slave bus
);
   localparam int unsigned LANES = DATA_W / LANE_W;
   localparam int unsigned L     = $clog2(LANES);
   localparam int unsigned NP    = 1 << L;
   localparam int unsigned TW    = LANE_W + 1 + L;
   localparam int unsigned EW    = OUT_W + 1;

   localparam logic [OUT_W-1:0] U_MAX = '1;
   localparam logic [OUT_W-1:0] S_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] S_MIN = {1'b1, {(OUT_W-1){1'b0}}};

   if ((DATA_W % LANE_W) != 0 || LANES < 2) begin : g_bad_lanes
      $error("red_pipe: DATA_W must be a multiple of LANE_W with at least two lanes");
   end
   if (OUT_W < TW) begin : g_bad_outw
      $error("red_pipe: OUT_W must be at least LANE_W+1+clog2(LANES)");
   end

   logic                 en;
   logic [NP*LANE_W-1:0] pad_data;
   logic [TW-1:0]        ext_lane [NP];
   logic [L:0]           vld_q;
   logic [L:0]           sgn_q;
   logic [L:0]           cont_q;
   logic [TW-1:0]        tree_sum;

   logic                 out_valid_q, out_valid_d;
   logic [OUT_W-1:0]     acc_q, acc_d;
   logic                 ovf_q, ovf_d;
   logic                 op_sgn;
   logic                 ovf_hit;
   logic [EW-1:0]        t_ext, a_ext, sum_w;

   assign en           = ~out_valid_q | bus.out_ready;
   assign bus.in_ready = en;

   always_comb begin
      pad_data           = '0;
      pad_data[DATA_W-1:0] = bus.in_data;
      for (int unsigned i = 0; i < NP; i++) begin
         ext_lane[i] = {{(TW-LANE_W){bus.in_signed & pad_data[i*LANE_W + LANE_W - 1]}},
                        pad_data[i*LANE_W +: LANE_W]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
      end else if (en) begin
         vld_q <= {vld_q[L-1:0], bus.in_valid};
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         sgn_q  <= {sgn_q[L-1:0], bus.in_signed};
         cont_q <= {cont_q[L-1:0], bus.in_acc};
      end
   end

   // Every tree level is TW wide; lanes are pre-extended so the sums are exact.
   for (genvar k = 0; k <= L; k++) begin : g_stg
      localparam int unsigned N = NP >> k;
      logic [TW-1:0] sum_q [N];
      if (k == 0) begin : g_ext
         always_ff @(posedge clk) begin
            if (en) begin
               sum_q <= ext_lane;
            end
         end
      end else begin : g_add
         always_ff @(posedge clk) begin
            if (en) begin
               for (int unsigned i = 0; i < N; i++) begin
                  sum_q[i] <= g_stg[k-1].sum_q[2*i] + g_stg[k-1].sum_q[2*i+1];
               end
            end
         end
      end
   end

   assign tree_sum = g_stg[L].sum_q[0];

   always_comb begin
      op_sgn      = sgn_q[L];
      t_ext       = {{(EW-TW){op_sgn & tree_sum[TW-1]}}, tree_sum};
      a_ext       = {op_sgn & acc_q[OUT_W-1], acc_q};
      sum_w       = a_ext + t_ext;
      ovf_hit     = op_sgn ? (sum_w[OUT_W] ^ sum_w[OUT_W-1]) : sum_w[OUT_W];
      out_valid_d = out_valid_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      if (en) begin
         out_valid_d = vld_q[L];
         if (vld_q[L]) begin
            if (!cont_q[L]) begin
               acc_d = t_ext[OUT_W-1:0];
               ovf_d = 1'b0;
            end else if (ovf_hit) begin
               ovf_d = 1'b1;
               if (SAT) begin
                  acc_d = !op_sgn ? U_MAX : (sum_w[OUT_W] ? S_MIN : S_MAX);
               end else begin
                  acc_d = sum_w[OUT_W-1:0];
               end
            end else begin
               acc_d = sum_w[OUT_W-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_result = acc_q;
   assign bus.out_ovf    = ovf_q;
endmodule

// File: tb/tb_red_pipe.sv
// Directed bench for red_pipe: default build plus OUT_W=8 saturating and wrapping builds.
module tb_red_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   red_pipe_if #(.DATA_W(16), .OUT_W(16)) b0 ();
   red_pipe_if #(.DATA_W(16), .OUT_W(8))  b1 ();
   red_pipe_if #(.DATA_W(16), .OUT_W(8))  b2 ();

   red_pipe #(.DATA_W(16), .LANE_W(4), .OUT_W(16), .SAT(1'b0)) u_def (.clk(clk), .rst(rst), .bus(b0));
   red_pipe #(.DATA_W(16), .LANE_W(4), .OUT_W(8),  .SAT(1'b1)) u_sat (.clk(clk), .rst(rst), .bus(b1));
   red_pipe #(.DATA_W(16), .LANE_W(4), .OUT_W(8),  .SAT(1'b0)) u_wrp (.clk(clk), .rst(rst), .bus(b2));

   typedef struct {
      logic [15:0] data; logic sgn; logic acc; logic [15:0] res; logic ovf;
   } vec_t;
   typedef struct {
      logic [15:0] data; logic sgn; logic acc;
      logic [7:0]  rs; logic os; logic [7:0] rw; logic ow;
   } pvec_t;

   vec_t  tv [8];
   vec_t  st [6];
   pvec_t pv [20];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic send0(input logic [15:0] d, input logic s, input logic a, output int lat);
      @(negedge clk);
      b0.in_valid = 1'b1; b0.in_data = d; b0.in_signed = s; b0.in_acc = a;
      @(negedge clk);
      b0.in_valid = 1'b0;
      lat = 1;
      while (!b0.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic send_pair(input logic [15:0] d, input logic s, input logic a, output int lat);
      @(negedge clk);
      b1.in_valid = 1'b1; b1.in_data = d; b1.in_signed = s; b1.in_acc = a;
      b2.in_valid = 1'b1; b2.in_data = d; b2.in_signed = s; b2.in_acc = a;
      @(negedge clk);
      b1.in_valid = 1'b0;
      b2.in_valid = 1'b0;
      lat = 1;
      while (!b1.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat;
      int idx;
      int got;
      int cyc;
      int extra;
      logic stall;

      tv[0] = '{16'hFFFF, 1'b1, 1'b0, 16'hFFFC, 1'b0};
      tv[1] = '{16'hFFFF, 1'b0, 1'b0, 16'h003C, 1'b0};
      tv[2] = '{16'h8888, 1'b1, 1'b0, 16'hFFE0, 1'b0};
      tv[3] = '{16'h7777, 1'b1, 1'b0, 16'h001C, 1'b0};
      tv[4] = '{16'h7777, 1'b1, 1'b1, 16'h0038, 1'b0};
      tv[5] = '{16'h8888, 1'b1, 1'b1, 16'h0018, 1'b0};
      tv[6] = '{16'hFFFF, 1'b0, 1'b1, 16'h0054, 1'b0};
      tv[7] = '{16'h9ABC, 1'b1, 1'b0, 16'hFFEA, 1'b0};

      st[0] = '{16'h1111, 1'b1, 1'b0, 16'h0004, 1'b0};
      st[1] = '{16'h2222, 1'b1, 1'b0, 16'h0008, 1'b0};
      st[2] = '{16'h3333, 1'b1, 1'b0, 16'h000C, 1'b0};
      st[3] = '{16'h1234, 1'b1, 1'b0, 16'h000A, 1'b0};
      st[4] = '{16'hFFFF, 1'b0, 1'b0, 16'h003C, 1'b0};
      st[5] = '{16'hFFFF, 1'b1, 1'b0, 16'hFFFC, 1'b0};

      pv[0]  = '{16'h7777, 1'b1, 1'b0, 8'h1C, 1'b0, 8'h1C, 1'b0};
      pv[1]  = '{16'h7777, 1'b1, 1'b1, 8'h38, 1'b0, 8'h38, 1'b0};
      pv[2]  = '{16'h7777, 1'b1, 1'b1, 8'h54, 1'b0, 8'h54, 1'b0};
      pv[3]  = '{16'h7777, 1'b1, 1'b1, 8'h70, 1'b0, 8'h70, 1'b0};
      pv[4]  = '{16'h7777, 1'b1, 1'b1, 8'h7F, 1'b1, 8'h8C, 1'b1};
      pv[5]  = '{16'h0001, 1'b1, 1'b0, 8'h01, 1'b0, 8'h01, 1'b0};
      pv[6]  = '{16'hFFFF, 1'b0, 1'b0, 8'h3C, 1'b0, 8'h3C, 1'b0};
      pv[7]  = '{16'hFFFF, 1'b0, 1'b1, 8'h78, 1'b0, 8'h78, 1'b0};
      pv[8]  = '{16'hFFFF, 1'b0, 1'b1, 8'hB4, 1'b0, 8'hB4, 1'b0};
      pv[9]  = '{16'hFFFF, 1'b0, 1'b1, 8'hF0, 1'b0, 8'hF0, 1'b0};
      pv[10] = '{16'hFFFF, 1'b0, 1'b1, 8'hFF, 1'b1, 8'h2C, 1'b1};
      pv[11] = '{16'hFFFF, 1'b0, 1'b1, 8'hFF, 1'b1, 8'h68, 1'b1};
      pv[12] = '{16'hFFFF, 1'b0, 1'b1, 8'hFF, 1'b1, 8'hA4, 1'b1};
      pv[13] = '{16'hFFFF, 1'b0, 1'b1, 8'hFF, 1'b1, 8'hE0, 1'b1};
      pv[14] = '{16'h8888, 1'b1, 1'b0, 8'hE0, 1'b0, 8'hE0, 1'b0};
      pv[15] = '{16'h8888, 1'b1, 1'b1, 8'hC0, 1'b0, 8'hC0, 1'b0};
      pv[16] = '{16'h8888, 1'b1, 1'b1, 8'hA0, 1'b0, 8'hA0, 1'b0};
      pv[17] = '{16'h8888, 1'b1, 1'b1, 8'h80, 1'b0, 8'h80, 1'b0};
      pv[18] = '{16'h8888, 1'b1, 1'b1, 8'h80, 1'b1, 8'h60, 1'b1};
      pv[19] = '{16'h0001, 1'b0, 1'b1, 8'h81, 1'b1, 8'h61, 1'b1};

      b0.in_valid = 1'b0; b0.in_data = '0; b0.in_signed = 1'b0; b0.in_acc = 1'b0; b0.out_ready = 1'b1;
      b1.in_valid = 1'b0; b1.in_data = '0; b1.in_signed = 1'b0; b1.in_acc = 1'b0; b1.out_ready = 1'b1;
      b2.in_valid = 1'b0; b2.in_data = '0; b2.in_signed = 1'b0; b2.in_acc = 1'b0; b2.out_ready = 1'b1;

      // reset state
      #2 rst = 1'b1;
      #1;
      chk("rst_valid",  32'(b0.out_valid),  32'd0);
      chk("rst_result", 32'(b0.out_result), 32'd0);
      chk("rst_ovf",    32'(b0.out_ovf),    32'd0);
      chk("rst_ready",  32'(b0.in_ready),   32'd1);
      repeat (2) @(negedge clk);
      #3 rst = 1'b0;

      // single-op vectors on the default build
      for (int i = 0; i < 8; i++) begin
         send0(tv[i].data, tv[i].sgn, tv[i].acc, lat);
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
         chk($sformatf("vec%0d_res", i), 32'(b0.out_result), 32'(tv[i].res));
         chk($sformatf("vec%0d_ovf", i), 32'(b0.out_ovf), 32'(tv[i].ovf));
      end

      // back-to-back stream with a 3-cycle output stall
      idx = 0; got = 0; cyc = 0;
      while (got < 6 && cyc < 60) begin
         @(negedge clk);
         stall = (cyc >= 5 && cyc <= 7);
         b0.out_ready = !stall;
         if (idx < 6) begin
            b0.in_valid = 1'b1; b0.in_data = st[idx].data;
            b0.in_signed = st[idx].sgn; b0.in_acc = st[idx].acc;
         end else begin
            b0.in_valid = 1'b0;
         end
         #1;
         if (stall) begin
            chk($sformatf("stall%0d_in_ready", cyc), 32'(b0.in_ready), 32'd0);
            chk($sformatf("stall%0d_valid", cyc), 32'(b0.out_valid), 32'd1);
            chk($sformatf("stall%0d_hold", cyc), 32'(b0.out_result), 32'(st[got].res));
         end
         if (b0.out_valid && b0.out_ready) begin
            chk($sformatf("stream%0d_res", got), 32'(b0.out_result), 32'(st[got].res));
            got++;
         end
         if (b0.in_valid && b0.in_ready) idx++;
         cyc++;
      end
      chk("stream_count", 32'(got), 32'd6);
      b0.in_valid = 1'b0;
      b0.out_ready = 1'b1;
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (b0.out_valid) extra++;
      end
      chk("stream_extra", 32'(extra), 32'd0);

      // asynchronous reset with three ops in flight
      @(negedge clk);
      b0.in_valid = 1'b1; b0.in_data = 16'h7777; b0.in_signed = 1'b1; b0.in_acc = 1'b0;
      repeat (3) @(negedge clk);
      b0.in_valid = 1'b0;
      @(posedge clk);
      #3;
      chk("pre_rst_valid", 32'(b0.out_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid",  32'(b0.out_valid),  32'd0);
      chk("mid_rst_result", 32'(b0.out_result), 32'd0);
      chk("mid_rst_ovf",    32'(b0.out_ovf),    32'd0);
      chk("mid_rst_ready",  32'(b0.in_ready),   32'd1);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (b0.out_valid) extra++;
      end
      chk("post_rst_stale", 32'(extra), 32'd0);
      send0(16'h7777, 1'b1, 1'b1, lat);
      chk("acc_from_zero_lat", 32'(lat), 32'd4);
      chk("acc_from_zero_res", 32'(b0.out_result), 32'h001C);
      chk("acc_from_zero_ovf", 32'(b0.out_ovf), 32'd0);

      // OUT_W=8 saturating and wrapping accumulation chains
      for (int i = 0; i < 20; i++) begin
         send_pair(pv[i].data, pv[i].sgn, pv[i].acc, lat);
         chk($sformatf("pair%0d_lat", i), 32'(lat), 32'd4);
         chk($sformatf("pair%0d_wrp_valid", i), 32'(b2.out_valid), 32'd1);
         chk($sformatf("pair%0d_sat_res", i), 32'(b1.out_result), 32'(pv[i].rs));
         chk($sformatf("pair%0d_sat_ovf", i), 32'(b1.out_ovf), 32'(pv[i].os));
         chk($sformatf("pair%0d_wrp_res", i), 32'(b2.out_result), 32'(pv[i].rw));
         chk($sformatf("pair%0d_wrp_ovf", i), 32'(b2.out_ovf), 32'(pv[i].ow));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
